ball_motion: RTL

//  Pong ball engine. Consumes the left/right paddle boxes and the playfield border, and owns the ball box.

---
 rtl/ball_motion.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ball_motion.sv
// ball_motion: Pong ball engine with wall/paddle bounces, goal detection and serve hold-off.
// Define BALL_SPEEDUP_EN to add 1 to the horizontal step per paddle hit, up to MAX_STEP.
module ball_motion #(
  parameter int TICK_DIV   = 1666667,
  parameter int BALL_SIZE  = 8,
  parameter int STEP       = 2,
  parameter int START_H    = 316,
  parameter int START_V    = 236,
  parameter int HOLD_TICKS = 60,
  parameter int MAX_STEP   = 6
) (
  input  logic       CLK_100MHz,
  input  logic       Reset,
  input  logic [9:0] borderHmin,
  input  logic [9:0] borderHmax,
  input  logic [9:0] borderVmin,
  input  logic [9:0] borderVmax,
  input  logic [9:0] lHmin,
  input  logic [9:0] lHmax,
  input  logic [9:0] lVmin,
  input  logic [9:0] lVmax,
  input  logic [9:0] rHmin,
  input  logic [9:0] rHmax,
  input  logic [9:0] rVmin,
  input  logic [9:0] rVmax,
  input  logic       Serve,
  output logic [9:0] Hmin,
  output logic [9:0] Hmax,
  output logic [9:0] Vmin,
  output logic [9:0] Vmax,
  output logic       scoreL,
  output logic       scoreR,
  output logic       hit,
  output logic       inPlay
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  localparam logic signed [11:0] BS1 = 12'(BALL_SIZE - 1);
  localparam logic signed [11:0] VST = 12'(STEP);
  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [9:0] step_x, step_nx, hmin_nx, vmin_nx;
  logic tick, dir_x, dir_y, dir_x_nx, dir_y_nx, score_l_nx, score_r_nx, hit_nx;
  logic v_top, v_bot, l_hit, r_hit, goal_l, goal_r, last_hold, unused;
  logic signed [11:0] h, v, nh, nv;

  // Edge math is widened and signed so nothing wraps near 0 or 1023.
  function automatic logic signed [11:0] s(input logic [9:0] x);
    return $signed({2'b00, x});
  endfunction

  assign tick = cnt == CW'(TICK_DIV - 1);
  assign last_hold = hold_cnt == HW'(HOLD_TICKS - 1);
  assign Hmax = Hmin + 10'(BALL_SIZE - 1);
  assign Vmax = Vmin + 10'(BALL_SIZE - 1);
  assign unused = ^{lHmin, rHmax, 10'(MAX_STEP)};

  always_comb begin
    h = s(Hmin);
    v = s(Vmin);
    nh = dir_x ? h + s(step_x) : h - s(step_x);
    nv = dir_y ? v + VST : v - VST;
    v_top = nv <= s(borderVmin);
    v_bot = nv + BS1 >= s(borderVmax);
    l_hit = !dir_x && nh <= s(lHmax) && h > s(lHmax) && v + BS1 >= s(lVmin) && v <= s(lVmax);
    r_hit = dir_x && nh + BS1 >= s(rHmin) && h + BS1 < s(rHmin) && v + BS1 >= s(rVmin) && v <= s(rVmax);
    goal_r = !dir_x && !l_hit && nh <= s(borderHmin);
    goal_l = dir_x && !r_hit && nh + BS1 >= s(borderHmax);
  end

  always_comb begin
    state_nx = state;
    hold_nx = hold_cnt;
    step_nx = step_x;
    hmin_nx = Hmin;
    vmin_nx = Vmin;
    dir_x_nx = dir_x;
    dir_y_nx = dir_y;
    score_l_nx = 1'b0;
    score_r_nx = 1'b0;
    hit_nx = 1'b0;
    if (state == IDLE && Serve) state_nx = MOVE;
    if (state == MOVE && tick) begin
      // A goal freezes the box and aims the next serve at the conceding side.
      if (goal_l || goal_r) begin
        state_nx = HOLD;
        score_l_nx = goal_l;
        score_r_nx = goal_r;
        dir_x_nx = goal_l;
        step_nx = 10'(STEP);
      end else begin
        hmin_nx = 10'(l_hit ? s(lHmax) + 12'sd1 : r_hit ? s(rHmin) - BS1 - 12'sd1 : nh);
        vmin_nx = 10'(v_top ? s(borderVmin) + 12'sd1 : v_bot ? s(borderVmax) - BS1 - 12'sd1 : nv);
        dir_x_nx = dir_x ^ (l_hit | r_hit);
        dir_y_nx = dir_y ^ (v_top | v_bot);
        hit_nx = l_hit | r_hit;
`ifdef BALL_SPEEDUP_EN
        if ((l_hit | r_hit) && step_x < 10'(MAX_STEP)) step_nx = step_x + 10'd1;
`endif
      end
    end
    if (state == HOLD && tick) begin
      hold_nx = last_hold ? '0 : hold_cnt + 1'b1;
      state_nx = last_hold ? IDLE : HOLD;
      hmin_nx = last_hold ? 10'(START_H) : Hmin;
      vmin_nx = last_hold ? 10'(START_V) : Vmin;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt <= '0;
      hold_cnt <= '0;
      step_x <= 10'(STEP);
      Hmin <= 10'(START_H);
      Vmin <= 10'(START_V);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      scoreL <= 1'b0;
      scoreR <= 1'b0;
      hit <= 1'b0;
      inPlay <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      state <= state_nx;
      hold_cnt <= hold_nx;
      step_x <= step_nx;
      Hmin <= hmin_nx;
      Vmin <= vmin_nx;
      dir_x <= dir_x_nx;
      dir_y <= dir_y_nx;
      scoreL <= score_l_nx;
      scoreR <= score_r_nx;
      hit <= hit_nx;
      inPlay <= state == MOVE;
    end
  end
endmodule
